// File: rtl/alu_operand_fetch.sv
// Operand fetch / issue stage feeding the ALU: GPR read with writeback bypass,
// pending-write scoreboard for RAW/WAW blocking, one registered valid/ready output stage.
module alu_operand_fetch #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_GPR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_reg_a,
    output logic [DATA_W-1:0] out_reg_b,
    output logic [31:0]       pend_mask
);

    // Returns {has_dest, dest_index}; a destination of GPR0 is treated as none.
    function automatic logic [5:0] dest_of(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        logic       has;
        logic [4:0] d;
        op  = instr[31:26];
        fn  = instr[5:0];
        has = 1'b0;
        d   = instr[15:11];
        if (op == 6'h00) begin
            has = fn inside {[6'h20:6'h27], 6'h2A, 6'h2B, 6'h00, 6'h02,
                             6'h03, 6'h04, 6'h06, 6'h07};
        end else if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23}) begin
            has = 1'b1;
            d   = instr[20:16];
        end
        if (d == 5'd0) has = 1'b0;
        return {has, d};
    endfunction

    logic [DATA_W-1:0] gpr [32];
    logic [31:0]       pend;
    logic [31:0]       pend_eff;
    logic [31:0]       pend_nxt;
    logic [31:0]       wb_clr;

    logic              vld_p1;
    logic [31:0]       instr_p1;
    logic [DATA_W-1:0] reg_a_p1;
    logic [DATA_W-1:0] reg_b_p1;

    logic [4:0]        rs_p0;
    logic [4:0]        rt_p0;
    logic [5:0]        dst_p0;
    logic              hz_p0;
    logic              accept_p0;
    logic [DATA_W-1:0] reg_a_p0;
    logic [DATA_W-1:0] reg_b_p0;

    assign rs_p0  = in_instr[25:21];
    assign rt_p0  = in_instr[20:16];
    assign dst_p0 = dest_of(in_instr);

    // A pending bit being retired by this cycle's writeback no longer blocks.
    assign wb_clr   = wb_en ? (32'd1 << wb_addr) : 32'd0;
    assign pend_eff = pend & ~wb_clr & 32'hFFFF_FFFE;

    assign hz_p0     = pend_eff[rs_p0] | pend_eff[rt_p0] | (dst_p0[5] & pend_eff[dst_p0[4:0]]);
    assign in_ready  = !rst && !hz_p0 && (!vld_p1 || out_ready);
    assign accept_p0 = in_valid && in_ready;

    always_comb begin
        reg_a_p0 = gpr[rs_p0];
        if (wb_en && wb_addr == rs_p0) reg_a_p0 = wb_data;
        if (rs_p0 == 5'd0) reg_a_p0 = '0;
        reg_b_p0 = gpr[rt_p0];
        if (wb_en && wb_addr == rt_p0) reg_b_p0 = wb_data;
        if (rt_p0 == 5'd0) reg_b_p0 = '0;
    end

    // Set after clear so an issue to the same index as this cycle's writeback stays pending.
    always_comb begin
        pend_nxt = pend & ~wb_clr;
        if (accept_p0 && dst_p0[5]) pend_nxt[dst_p0[4:0]] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // ---- p0 -> p1: issue register and architectural state ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            instr_p1 <= '0;
            reg_a_p1 <= '0;
            reg_b_p1 <= '0;
            pend     <= '0;
            for (int i = 0; i < 32; i++) gpr[i] <= RESET_GPR;
        end else begin
            if (accept_p0) begin
                vld_p1   <= 1'b1;
                instr_p1 <= in_instr;
                reg_a_p1 <= reg_a_p0;
                reg_b_p1 <= reg_b_p0;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
            pend <= pend_nxt;
            if (wb_en && wb_addr != 5'd0) gpr[wb_addr] <= wb_data;
        end
    end

    assign out_valid = vld_p1;
    assign out_instr = instr_p1;
    assign out_reg_a = reg_a_p1;
    assign out_reg_b = reg_b_p1;
    assign pend_mask = pend;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch: issue, hazard stall/bypass, backpressure,
// GPR0 handling, same-cycle set/clear, and mid-operation reset.
module tb_alu_operand_fetch;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [DATA_W-1:0] out_reg_a;
    logic [DATA_W-1:0] out_reg_b;
    logic [31:0]       pend_mask;

    int n_chk  = 0;
    int n_pass = 0;

    alu_operand_fetch #(.DATA_W(DATA_W), .RESET_GPR('0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_reg_a (out_reg_a),
        .out_reg_b (out_reg_b),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        step();
        wb_en   = 1'b0;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [31:0] i_a;
    logic [31:0] i_b;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b1;
        in_instr = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_reg_a", out_reg_a, 32'd0);
        check("rst_reg_b", out_reg_b, 32'd0);
        check("rst_pend", pend_mask, 32'd0);

        // T1: addu r3,r1,r2
        wb(5'd1, 32'd5);
        wb(5'd2, 32'd7);
        i_a = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        in_valid = 1'b1;
        in_instr = i_a;
        #1;
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("t1_out_valid", {31'd0, out_valid}, 32'd1);
        check("t1_out_instr", out_instr, i_a);
        check("t1_reg_a", out_reg_a, 32'd5);
        check("t1_reg_b", out_reg_b, 32'd7);
        check("t1_pend", pend_mask, 32'h8);
        step();
        check("t1_drain_valid", {31'd0, out_valid}, 32'd0);
        check("t1_drain_hold_a", out_reg_a, 32'd5);

        // T2: subu r4,r3,r1 stalls on r3 until writeback, which also bypasses
        i_b = rtype(5'd3, 5'd1, 5'd4, 6'h23);
        in_valid = 1'b1;
        in_instr = i_b;
        #1;
        check("t2_stall0", {31'd0, in_ready}, 32'd0);
        step();
        check("t2_stall1", {31'd0, in_ready}, 32'd0);
        check("t2_stall_valid", {31'd0, out_valid}, 32'd0);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h10;
        #1;
        check("t2_release", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0; wb_en = 1'b0;
        check("t2_out_valid", {31'd0, out_valid}, 32'd1);
        check("t2_out_instr", out_instr, i_b);
        check("t2_bypass_a", out_reg_a, 32'h10);
        check("t2_reg_b", out_reg_b, 32'd5);
        check("t2_pend", pend_mask, 32'h10);
        wb(5'd4, 32'h44);
        check("t2_pend_clr", pend_mask, 32'd0);

        // T3: backpressure for 4 cycles with a second instruction waiting
        i_a = rtype(5'd1, 5'd2, 5'd6, 6'h21);
        i_b = rtype(5'd2, 5'd1, 5'd7, 6'h21);
        in_valid = 1'b1;
        in_instr = i_a;
        step();
        in_instr = i_b;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_hold_ready", {31'd0, in_ready}, 32'd0);
            check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t3_hold_instr", out_instr, i_a);
            check("t3_hold_a", out_reg_a, 32'd5);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("t3_resume", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("t3_second_instr", out_instr, i_b);
        check("t3_second_a", out_reg_a, 32'd7);
        check("t3_second_valid", {31'd0, out_valid}, 32'd1);
        step();
        check("t3_drained", {31'd0, out_valid}, 32'd0);
        check("t3_pend", pend_mask, 32'hC0);
        wb(5'd6, 32'd0);
        wb(5'd7, 32'd0);

        // T4: GPR0 destination and writes, no-dest opcodes
        i_a = itype(6'h08, 5'd0, 5'd0, 16'd1);
        in_valid = 1'b1;
        in_instr = i_a;
        step();
        in_valid = 1'b0;
        check("t4_addi_valid", {31'd0, out_valid}, 32'd1);
        check("t4_addi_pend", pend_mask, 32'd0);
        wb(5'd0, 32'hFFFF);
        check("t4_wb0_pend", pend_mask, 32'd0);
        in_valid = 1'b1;
        in_instr = rtype(5'd0, 5'd0, 5'd8, 6'h21);
        step();
        in_valid = 1'b0;
        check("t4_gpr0_a", out_reg_a, 32'd0);
        check("t4_gpr0_b", out_reg_b, 32'd0);
        check("t4_r8_pend", pend_mask, 32'h100);
        wb(5'd8, 32'h80);
        in_valid = 1'b1;
        in_instr = itype(6'h2B, 5'd1, 5'd2, 16'h4);
        step();
        check("t4_sw_pend", pend_mask, 32'd0);
        check("t4_sw_reg_b", out_reg_b, 32'd7);
        in_instr = itype(6'h04, 5'd1, 5'd2, 16'h8);
        step();
        in_valid = 1'b0;
        check("t4_beq_pend", pend_mask, 32'd0);
        check("t4_beq_valid", {31'd0, out_valid}, 32'd1);

        // T5: accept with dest r5 while writeback clears r5: set wins
        in_valid = 1'b1;
        in_instr = rtype(5'd1, 5'd2, 5'd5, 6'h21);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'd9;
        step();
        wb_en = 1'b0;
        check("t5_pend", pend_mask, 32'h20);
        check("t5_valid", {31'd0, out_valid}, 32'd1);
        in_instr = rtype(5'd5, 5'd1, 5'd9, 6'h21);
        #1;
        check("t5_raw_stall", {31'd0, in_ready}, 32'd0);

        // T6: reset while output valid and r4/r5 pending; writeback during reset is ignored
        in_instr = rtype(5'd1, 5'd2, 5'd4, 6'h21);
        step();
        in_valid = 1'b0;
        check("t6_pre_pend", pend_mask, 32'h30);
        check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        rst = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h99;
        step();
        rst = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_pend", pend_mask, 32'd0);
        check("t6_instr", out_instr, 32'd0);
        in_valid = 1'b1;
        in_instr = rtype(5'd1, 5'd2, 5'd10, 6'h21);
        step();
        in_valid = 1'b0;
        check("t6_gpr1_reset", out_reg_a, 32'd0);
        check("t6_gpr2_reset", out_reg_b, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
